// File: rtl/mult_share_arbiter.sv
// Round-robin share of one signed SIZE x SIZE multiplier across NREQ requesters, 2-stage pipeline.
// Define MULT_SHARE_ARBITER_STATS_EN to add saturating stat_done / stat_stall counters.

module multiplier_bw_signed #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0]   i_a,
    input  logic [SIZE-1:0]   i_b,
    output logic [2*SIZE-1:0] o_y
);
    logic [2*SIZE-1:0] w_a_ext;
    logic [2*SIZE-1:0] w_b_ext;

    // Low 2*SIZE bits of the sign-extended product are the exact signed product.
    assign w_a_ext = {{SIZE{i_a[SIZE-1]}}, i_a};
    assign w_b_ext = {{SIZE{i_b[SIZE-1]}}, i_b};
    assign o_y     = w_a_ext * w_b_ext;
endmodule

module mult_share_arbiter #(
    parameter int SIZE = 32,
    parameter int NREQ = 4,
    localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*SIZE-1:0] req_a,
    input  logic [NREQ*SIZE-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*SIZE-1:0]    rsp_y,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
`ifdef MULT_SHARE_ARBITER_STATS_EN
    ,
    output logic [31:0]          stat_done,
    output logic [31:0]          stat_stall
`endif
);
    logic              r_s1_v;
    logic [SIZE-1:0]   r_s1_a;
    logic [SIZE-1:0]   r_s1_b;
    logic [IDW-1:0]    r_s1_id;
    logic              r_s2_v;
    logic [2*SIZE-1:0] r_s2_y;
    logic [IDW-1:0]    r_s2_id;
    logic [IDW-1:0]    r_rr_ptr;

    logic              w_s2_en;
    logic              w_issue_ok;
    logic              w_gnt_vld;
    logic [IDW-1:0]    w_gnt_id;
    logic              w_xfer;
    logic [IDW-1:0]    w_rr_nxt;
    logic [2*SIZE-1:0] w_prod;

    assign w_s2_en    = !r_s2_v | rsp_ready;
    // Gated by rst_n so nothing can handshake while reset is held.
    assign w_issue_ok = rst_n & (!r_s1_v | w_s2_en);
    assign w_xfer     = w_issue_ok & w_gnt_vld;
    assign w_rr_nxt   = (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + 1'b1;

    // Walk downward so the requester closest above rr_ptr wins.
    always_comb begin
        int idx;
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_xfer) req_ready[w_gnt_id] = 1'b1;
    end

    multiplier_bw_signed #(.SIZE(SIZE)) u_mul (
        .i_a (r_s1_a),
        .i_b (r_s1_b),
        .o_y (w_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v   <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_id  <= '0;
            r_s2_v   <= 1'b0;
            r_s2_y   <= '0;
            r_s2_id  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_s2_en) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_s2_y  <= w_prod;
                    r_s2_id <= r_s1_id;
                end
            end
            if (w_issue_ok) begin
                r_s1_v <= w_gnt_vld;
                if (w_gnt_vld) begin
                    r_s1_a   <= req_a[w_gnt_id*SIZE +: SIZE];
                    r_s1_b   <= req_b[w_gnt_id*SIZE +: SIZE];
                    r_s1_id  <= w_gnt_id;
                    r_rr_ptr <= w_rr_nxt;
                end
            end
        end
    end

    assign rsp_valid = r_s2_v;
    assign rsp_y     = r_s2_y;
    assign rsp_id    = r_s2_id;
    assign busy      = r_s1_v | r_s2_v;

`ifdef MULT_SHARE_ARBITER_STATS_EN
    logic [31:0] r_stat_done;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_done  <= '0;
            r_stat_stall <= '0;
        end else begin
            if (r_s2_v && rsp_ready && (r_stat_done != '1))
                r_stat_done <= r_stat_done + 1'b1;
            if (r_s2_v && !rsp_ready && (r_stat_stall != '1))
                r_stat_stall <= r_stat_stall + 1'b1;
        end
    end

    assign stat_done  = r_stat_done;
    assign stat_stall = r_stat_stall;
`endif
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter (SIZE=8, NREQ=4): directed vector table, multi-cycle corner
// sequences and a randomized phase checked against a cycle-level reference model.
module tb_mult_share_arbiter;
    localparam int SIZE = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*SIZE-1:0] req_a = '0;
    logic [NREQ*SIZE-1:0] req_b = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic [2*SIZE-1:0]    rsp_y;
    logic [IDW-1:0]       rsp_id;
    logic                 busy;
`ifdef MULT_SHARE_ARBITER_STATS_EN
    logic [31:0]          stat_done;
    logic [31:0]          stat_stall;
`endif

    always #5 clk = ~clk;

    mult_share_arbiter #(.SIZE(SIZE), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_y      (rsp_y),
        .rsp_id     (rsp_id),
        .busy       (busy)
`ifdef MULT_SHARE_ARBITER_STATS_EN
        ,
        .stat_done  (stat_done),
        .stat_stall (stat_stall)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: two pipeline slots, round-robin pointer, acceptance/response logs.
    bit                m1_v, m2_v;
    int                m1_id, m2_id;
    logic [2*SIZE-1:0] m1_y, m2_y;
    int                m_rr;
    int                n_hs;
    int                acc_q[$];
    int                rsp_q[$];

    typedef struct {
        logic [SIZE-1:0]   a;
        logic [SIZE-1:0]   b;
        int                id;
        logic [2*SIZE-1:0] y;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*SIZE-1:0] prod(int i);
        logic signed [SIZE-1:0] sa, sb;
        int pa, pb;
        sa = req_a[i*SIZE +: SIZE];
        sb = req_b[i*SIZE +: SIZE];
        pa = sa;
        pb = sb;
        return (2*SIZE)'(pa * pb);
    endfunction

    function automatic int exp_grant();
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [SIZE-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    // Called at a negedge with inputs driven; checks this cycle, advances model, returns at next negedge.
    task automatic step(output int acc);
        int g;
        bit s2en, iok;
        logic [NREQ-1:0] er;
        #1;
        s2en = !m2_v || rsp_ready;
        iok  = !m1_v || s2en;
        g    = exp_grant();
        er   = '0;
        if (iok && g >= 0) er[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("rsp_valid", 64'(rsp_valid), 64'(m2_v));
        if (m2_v) begin
            chk("rsp_y", 64'(rsp_y), 64'(m2_y));
            chk("rsp_id", 64'(rsp_id), 64'(m2_id));
        end
        chk("busy", 64'(busy), 64'(m1_v | m2_v));
        if (rsp_valid && rsp_ready) rsp_q.push_back(int'(rsp_id));
        @(posedge clk);
        acc = -1;
        if (m2_v && rsp_ready) n_hs++;
        if (s2en) begin
            m2_v  = m1_v;
            m2_y  = m1_y;
            m2_id = m1_id;
        end
        if (iok) begin
            m1_v = (g >= 0);
            if (g >= 0) begin
                m1_id = g;
                m1_y  = prod(g);
                m_rr  = (g + 1) % NREQ;
                acc_q.push_back(g);
                acc   = g;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_y", 64'(rsp_y), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
`ifdef MULT_SHARE_ARBITER_STATS_EN
        chk("rst_stat_done", 64'(stat_done), 64'd0);
        chk("rst_stat_stall", 64'(stat_stall), 64'd0);
`endif
        m1_v = 0; m2_v = 0; m_rr = 0; n_hs = 0;
        acc_q.delete();
        rsp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int acc;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 10 && (m1_v || m2_v); n++) step(acc);
        chk("drain_timeout", 64'(m1_v | m2_v), 64'd0);
    endtask

    task automatic check_order(string nm);
        chk({nm, "_count"}, 64'(rsp_q.size()), 64'(acc_q.size()));
        for (int i = 0; i < acc_q.size() && i < rsp_q.size(); i++)
            chk({nm, "_order"}, 64'(rsp_q[i]), 64'(acc_q[i]));
        acc_q.delete();
        rsp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int acc, n0;
        logic [2*SIZE-1:0] y_hold;
        logic [IDW-1:0]    id_hold;

        tbl[0] = '{8'h80, 8'h80, 0, 16'h4000};
        tbl[1] = '{8'h7F, 8'h80, 1, 16'hC080};
        tbl[2] = '{8'hFF, 8'h01, 2, 16'hFFFF};
        tbl[3] = '{8'h05, 8'hFD, 3, 16'hFFF1};

        // Requests raised during reset must not be granted.
        req_valid = '1;
        do_reset();
        req_valid = '0;

        // Directed vectors: single requester, latency 2, exact product.
        for (int v = 0; v < 4; v++) begin
            req_a[tbl[v].id*SIZE +: SIZE] = tbl[v].a;
            req_b[tbl[v].id*SIZE +: SIZE] = tbl[v].b;
            req_valid[tbl[v].id] = 1'b1;
            n0 = acc_q.size();
            for (int n = 0; n < 10 && acc_q.size() == n0; n++) step(acc);
            chk("vec_accept", 64'(acc_q.size()), 64'(n0 + 1));
            req_valid = '0;
            chk("vec_lat1_valid", 64'(rsp_valid), 64'd0);
            step(acc);
            chk("vec_lat2_valid", 64'(rsp_valid), 64'd1);
            chk("vec_y", 64'(rsp_y), 64'(tbl[v].y));
            chk("vec_id", 64'(rsp_id), 64'(tbl[v].id));
            drain();
        end
        check_order("vec");

        // All requesting continuously: strict rotation from 0, one grant per cycle.
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*SIZE +: SIZE] = rnd_op();
            req_b[i*SIZE +: SIZE] = rnd_op();
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            step(acc);
            chk("rr_grant", 64'(acc), 64'(n % NREQ));
            if (acc >= 0) begin
                req_a[acc*SIZE +: SIZE] = rnd_op();
                req_b[acc*SIZE +: SIZE] = rnd_op();
            end
        end

        // Stall 5 cycles with full pipeline.
        rsp_ready = 1'b0;
        y_hold  = rsp_y;
        id_hold = rsp_id;
        for (int n = 0; n < 5; n++) begin
            step(acc);
            chk("stall_y", 64'(rsp_y), 64'(y_hold));
            chk("stall_id", 64'(rsp_id), 64'(id_hold));
            chk("stall_ready", 64'(req_ready), 64'd0);
        end
        drain();
        check_order("stall");

        // Async reset while both stages hold entries.
        req_valid = '1;
        step(acc);
        step(acc);
        step(acc);
        do_reset();
        step(acc);
        chk("post_reset_grant", 64'(acc), 64'd0);
        drain();
        check_order("post_reset");

        // Randomized traffic with hold-until-accepted requesters and random backpressure.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_a[i*SIZE +: SIZE] = rnd_op();
                    req_b[i*SIZE +: SIZE] = rnd_op();
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step(acc);
            if (acc >= 0) req_valid[acc] = 1'b0;
        end
        drain();
        check_order("random");

`ifdef MULT_SHARE_ARBITER_STATS_EN
        do_reset();
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        step(acc);
        step(acc);
        for (int n = 0; n < 3; n++) step(acc);
        rsp_ready = 1'b1;
        for (int n = 0; n < 30 && n_hs < 10; n++) step(acc);
        chk("stat_done", 64'(stat_done), 64'd10);
        chk("stat_stall", 64'(stat_stall), 64'd3);
        drain();
        check_order("stats");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
